// File: rtl/dps_sweep_sequencer.sv
// Phase-shift sweep sequencer: steps a DPS controller from start to stop position,
// settling and requesting a measurement at every point along the way.
module dps_sweep_sequencer #(
    parameter int MOVE_TIMEOUT = 4096
) (
    input  logic               psclk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic signed [15:0] start_pos_i,
    input  logic signed [15:0] stop_pos_i,
    input  logic        [7:0]  step_size_i,
    input  logic        [15:0] dwell_cycles_i,
    input  logic signed [15:0] total_steps_i,
    input  logic               meas_ack_i,
    output logic               toggle_o,
    output logic               dir_o,
    output logic        [7:0]  steps_o,
    output logic               meas_req_o,
    output logic signed [15:0] cur_target_o,
    output logic        [15:0] point_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int TMO_W = $clog2(MOVE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MOVE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DWELL = 3'd4,
        S_MEAS  = 3'd5,
        S_NEXT  = 3'd6
    } state_t;

    // One burst is limited to 255 steps; larger distances take several bursts.
    function automatic logic [7:0] burst_len(input logic [16:0] d);
        logic [16:0] mag;
        mag = d[16] ? (17'd0 - d) : d;
        return (mag > 17'd255) ? 8'd255 : mag[7:0];
    endfunction

    state_t      state_r, state_n;
    logic        toggle_r, toggle_n;
    logic        dir_r, dir_n;
    logic [7:0]  steps_r, steps_n;
    logic        meas_req_r, meas_req_n;
    logic [15:0] cur_target_r, cur_target_n;
    logic [15:0] point_idx_r, point_idx_n;
    logic        busy_r, busy_n;
    logic        done_r, done_n;
    logic        err_r, err_n;
    logic [15:0] stop_r, stop_n;
    logic [7:0]  step_r, step_n;
    logic [15:0] dwell_r, dwell_n;
    logic        up_r, up_n;
    logic [16:0] delta_r, delta_n;
    logic [15:0] expected_r, expected_n;
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_n;
    logic [15:0] dwell_cnt_r, dwell_cnt_n;

    logic [16:0] delta_s;
    logic [16:0] next_s;
    logic [16:0] stop_ext_s;
    logic        next_ok_s;
    logic        dir_issue_s;
    logic [7:0]  burst_s;
    logic [15:0] expected_s;

    // Next-state and next-register computation for the sweep FSM.
    always_comb begin
        state_n      = state_r;
        toggle_n     = toggle_r;
        dir_n        = dir_r;
        steps_n      = steps_r;
        meas_req_n   = meas_req_r;
        cur_target_n = cur_target_r;
        point_idx_n  = point_idx_r;
        busy_n       = busy_r;
        done_n       = 1'b0;
        err_n        = err_r;
        stop_n       = stop_r;
        step_n       = step_r;
        dwell_n      = dwell_r;
        up_n         = up_r;
        delta_n      = delta_r;
        expected_n   = expected_r;
        tmo_cnt_n    = tmo_cnt_r;
        dwell_cnt_n  = dwell_cnt_r;

        delta_s     = {cur_target_r[15], cur_target_r} - {total_steps_i[15], total_steps_i};
        next_s      = up_r ? ({cur_target_r[15], cur_target_r} + {9'd0, step_r})
                           : ({cur_target_r[15], cur_target_r} - {9'd0, step_r});
        stop_ext_s  = {stop_r[15], stop_r};
        next_ok_s   = up_r ? ($signed(next_s) <= $signed(stop_ext_s))
                           : ($signed(next_s) >= $signed(stop_ext_s));
        dir_issue_s = ($signed(delta_r) > 17'sd0);
        burst_s     = burst_len(delta_r);
        expected_s  = dir_issue_s ? (total_steps_i + {8'd0, burst_s})
                                  : (total_steps_i - {8'd0, burst_s});

        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    if (step_size_i == 8'd0) begin
                        err_n = 1'b1;
                    end else begin
                        stop_n       = stop_pos_i;
                        step_n       = step_size_i;
                        dwell_n      = dwell_cycles_i;
                        up_n         = (stop_pos_i >= start_pos_i);
                        cur_target_n = start_pos_i;
                        point_idx_n  = 16'd0;
                        err_n        = 1'b0;
                        busy_n       = 1'b1;
                        state_n      = S_CALC;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_CALC: begin
                delta_n = delta_s;
                if (delta_s == 17'd0) begin
                    dwell_cnt_n = dwell_r;
                    state_n     = S_DWELL;
                end else begin
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                dir_n      = dir_issue_s;
                steps_n    = burst_s;
                expected_n = expected_s;
                toggle_n   = ~toggle_r;
                tmo_cnt_n  = '0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                if (total_steps_i == expected_r) begin
                    state_n = S_CALC;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt_r + TMO_W'(1);
                end
            end
            S_DWELL: begin
                if (dwell_cnt_r == 16'd0) begin
                    meas_req_n = 1'b1;
                    state_n    = S_MEAS;
                end else begin
                    dwell_cnt_n = dwell_cnt_r - 16'd1;
                end
            end
            S_MEAS: begin
                if (meas_ack_i) begin
                    meas_req_n  = 1'b0;
                    point_idx_n = point_idx_r + 16'd1;
                    state_n     = S_NEXT;
                end else begin
                    meas_req_n = 1'b1;
                end
            end
            S_NEXT: begin
                if (next_ok_s) begin
                    cur_target_n = next_s[15:0];
                    state_n      = S_CALC;
                end else begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                meas_req_n = 1'b0;
                busy_n     = 1'b0;
                state_n    = S_IDLE;
            end
        endcase

        // Abort wins over anything the current state wanted to do this cycle.
        if (abort_i && (state_r != S_IDLE)) begin
            state_n      = S_IDLE;
            meas_req_n   = 1'b0;
            busy_n       = 1'b0;
            done_n       = 1'b0;
            err_n        = err_r;
            point_idx_n  = point_idx_r;
            cur_target_n = cur_target_r;
            toggle_n     = toggle_r;
            dir_n        = dir_r;
            steps_n      = steps_r;
        end else begin
            state_n = state_n;
        end
    end

    // State and datapath registers.
    always_ff @(posedge psclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r      <= S_IDLE;
            toggle_r     <= 1'b0;
            dir_r        <= 1'b0;
            steps_r      <= 8'd0;
            meas_req_r   <= 1'b0;
            cur_target_r <= 16'd0;
            point_idx_r  <= 16'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            stop_r       <= 16'd0;
            step_r       <= 8'd0;
            dwell_r      <= 16'd0;
            up_r         <= 1'b0;
            delta_r      <= 17'd0;
            expected_r   <= 16'd0;
            tmo_cnt_r    <= '0;
            dwell_cnt_r  <= 16'd0;
        end else begin
            state_r      <= state_n;
            toggle_r     <= toggle_n;
            dir_r        <= dir_n;
            steps_r      <= steps_n;
            meas_req_r   <= meas_req_n;
            cur_target_r <= cur_target_n;
            point_idx_r  <= point_idx_n;
            busy_r       <= busy_n;
            done_r       <= done_n;
            err_r        <= err_n;
            stop_r       <= stop_n;
            step_r       <= step_n;
            dwell_r      <= dwell_n;
            up_r         <= up_n;
            delta_r      <= delta_n;
            expected_r   <= expected_n;
            tmo_cnt_r    <= tmo_cnt_n;
            dwell_cnt_r  <= dwell_cnt_n;
        end
    end

    assign toggle_o     = toggle_r;
    assign dir_o        = dir_r;
    assign steps_o      = steps_r;
    assign meas_req_o   = meas_req_r;
    assign cur_target_o = cur_target_r;
    assign point_idx_o  = point_idx_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_dps_sweep_sequencer.sv
// Bench for dps_sweep_sequencer: table-driven and random sweeps against an ideal
// phase-shift controller model, plus hand sequences for timeout, abort and reset.
module tb_dps_sweep_sequencer;

    logic               psclk_i = 1'b0;
    logic               rstn_i;
    logic               start_i;
    logic               abort_i;
    logic signed [15:0] start_pos_i;
    logic signed [15:0] stop_pos_i;
    logic        [7:0]  step_size_i;
    logic        [15:0] dwell_cycles_i;
    logic signed [15:0] total_steps_i;
    logic               meas_ack_i;
    logic               toggle_o;
    logic               dir_o;
    logic        [7:0]  steps_o;
    logic               meas_req_o;
    logic signed [15:0] cur_target_o;
    logic        [15:0] point_idx_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    dps_sweep_sequencer dut (
        .psclk_i(psclk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
        .start_pos_i(start_pos_i), .stop_pos_i(stop_pos_i), .step_size_i(step_size_i),
        .dwell_cycles_i(dwell_cycles_i), .total_steps_i(total_steps_i),
        .meas_ack_i(meas_ack_i), .toggle_o(toggle_o), .dir_o(dir_o), .steps_o(steps_o),
        .meas_req_o(meas_req_o), .cur_target_o(cur_target_o), .point_idx_o(point_idx_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 psclk_i = ~psclk_i;

    int n_pass = 0;
    int n_chk  = 0;

    // controller / measurement-unit model state
    bit   ack_en    = 1'b1;
    bit   freeze    = 1'b0;
    bit   burst_chk = 1'b0;
    int   acks      = 0;
    int   bursts    = 0;
    int   pending   = 0;
    int   ack_wait  = 0;
    int   env_d;
    int   env_e;
    bit   pdir      = 1'b0;
    logic last_tog  = 1'b0;
    int   tgt[$];

    typedef struct {
        int s;
        int e;
        int st;
        int dw;
        int pts;
        int tog;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Ideal phase-shift controller (one step per cycle) and measurement acknowledger.
    initial begin
        forever begin
            @(posedge psclk_i);
            #1;
            if (!rstn_i) begin
                last_tog = 1'b0;
                pending  = 0;
                if (ack_en) meas_ack_i = 1'b0;
            end else begin
                if (ack_en) begin
                    if (meas_req_o && ack_wait == 0 && !meas_ack_i) begin
                        meas_ack_i = 1'b1;
                        acks++;
                    end else begin
                        meas_ack_i = 1'b0;
                        if (!meas_req_o) ack_wait = $urandom_range(0, 3);
                        else if (ack_wait > 0) ack_wait--;
                    end
                end
                if (toggle_o != last_tog) begin
                    last_tog = toggle_o;
                    bursts++;
                    if (burst_chk && acks < tgt.size()) begin
                        env_d = tgt[acks] - int'(total_steps_i);
                        env_e = (iabs(env_d) > 255) ? 255 : iabs(env_d);
                        chk("burst_steps", int'(steps_o), env_e);
                        chk("burst_dir", int'(dir_o), (env_d > 0) ? 1 : 0);
                    end
                    pending = steps_o;
                    pdir    = dir_o;
                end
                if (pending > 0 && !freeze) begin
                    total_steps_i = pdir ? total_steps_i + 16'sd1 : total_steps_i - 16'sd1;
                    pending--;
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge psclk_i); #1 start_i = 1'b1;
        @(posedge psclk_i); #1 start_i = 1'b0;
    endtask

    task automatic run_sweep(input int s, input int e, input int st, input int dw,
                             input int exp_pts, input int exp_tog);
        int   prev;
        int   etog;
        int   seen;
        int   dones;
        int   cyc;
        logic prev_req;
        start_pos_i    = 16'(s);
        stop_pos_i     = 16'(e);
        step_size_i    = 8'(st);
        dwell_cycles_i = 16'(dw);
        tgt.delete();
        for (int k = 0; k < exp_pts; k++) tgt.push_back((e >= s) ? s + k * st : s - k * st);
        etog = exp_tog;
        if (etog < 0) begin
            etog = 0;
            prev = int'(total_steps_i);
            foreach (tgt[k]) begin
                etog += (iabs(tgt[k] - prev) + 254) / 255;
                prev = tgt[k];
            end
        end
        acks = 0; bursts = 0; burst_chk = 1'b1;
        pulse_start();
        if (st == 0) begin
            chk("step0_err", int'(err_o), 1);
            chk("step0_busy", int'(busy_o), 0);
            burst_chk = 1'b0;
            return;
        end
        chk("busy_after_start", int'(busy_o), 1);
        seen = 0; dones = 0; cyc = 0; prev_req = 1'b0;
        while (busy_o && cyc < 30000) begin
            @(negedge psclk_i);
            cyc++;
            if (meas_req_o && !prev_req) begin
                if (seen < tgt.size()) chk("meas_target", int'(cur_target_o), tgt[seen]);
                seen++;
            end
            prev_req = meas_req_o;
            if (done_o) dones++;
        end
        if (cyc >= 30000) chk("sweep_budget_expired", 0, 1);
        chk("points_seen", seen, exp_pts);
        chk("point_idx", int'(point_idx_o), exp_pts);
        chk("done_count", dones, 1);
        chk("err_clear", int'(err_o), 0);
        chk("toggle_count", bursts, etog);
        @(negedge psclk_i);
        chk("done_one_cycle", int'(done_o), 0);
        burst_chk = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_toggle"}, int'(toggle_o), 0);
        chk({tag, "_dir"}, int'(dir_o), 0);
        chk({tag, "_steps"}, int'(steps_o), 0);
        chk({tag, "_meas_req"}, int'(meas_req_o), 0);
        chk({tag, "_cur_target"}, int'(cur_target_o), 0);
        chk({tag, "_point_idx"}, int'(point_idx_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_err"}, int'(err_o), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   cnt;
        int   s;
        int   e;
        int   st;
        int   t0;
        int   dn;
        logic tog0;

        rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; meas_ack_i = 1'b0;
        start_pos_i = '0; stop_pos_i = '0; step_size_i = '0; dwell_cycles_i = '0;
        total_steps_i = '0;
        repeat (3) @(posedge psclk_i);
        @(negedge psclk_i);
        chk_all_zero("reset");
        rstn_i = 1'b1;

        vecs.push_back('{600, 600, 1, 2, 1, 3});     // large move from total 0
        vecs.push_back('{0, 10, 4, 3, 3, -1});       // up sweep
        vecs.push_back('{-5, -12, 3, 1, 3, -1});     // down sweep, negative start
        vecs.push_back('{20, 20, 7, 0, 1, -1});      // single point
        vecs.push_back('{0, 8, 4, 0, 3, -1});        // last point lands on stop
        vecs.push_back('{100, -100, 255, 1, 1, -1}); // step exceeds span
        vecs.push_back('{3, 3, 0, 0, 0, 0});         // step 0 rejected
        for (int i = 0; i < 4; i++) begin
            s  = int'($urandom_range(0, 600)) - 300;
            e  = s + int'($urandom_range(0, 600)) - 300;
            st = int'($urandom_range(20, 255));
            vecs.push_back('{s, e, st, int'($urandom_range(0, 4)), iabs(e - s) / st + 1, -1});
        end
        foreach (vecs[i])
            run_sweep(vecs[i].s, vecs[i].e, vecs[i].st, vecs[i].dw, vecs[i].pts, vecs[i].tog);

        // move timeout: controller never reports the burst
        freeze = 1'b1;
        t0 = int'(total_steps_i);
        start_pos_i = 16'(t0 + 5); stop_pos_i = 16'(t0 + 5); step_size_i = 8'd1;
        dwell_cycles_i = 16'd0;
        tog0 = toggle_o;
        pulse_start();
        cnt = 0;
        while (toggle_o == tog0 && cnt < 20) begin @(negedge psclk_i); cnt++; end
        chk("timeout_toggle_seen", int'(toggle_o != tog0), 1);
        cnt = 1; dn = 0;
        while (cnt < 5000) begin
            @(negedge psclk_i);
            if (done_o) dn++;
            if (err_o) break;
            cnt++;
        end
        chk("timeout_cycles", cnt, 4096);
        chk("timeout_err", int'(err_o), 1);
        chk("timeout_busy", int'(busy_o), 0);
        chk("timeout_no_done", dn, 0);
        freeze = 1'b0; pending = 0;

        // abort coinciding with acknowledge
        ack_en = 1'b0; meas_ack_i = 1'b0;
        t0 = int'(total_steps_i);
        start_pos_i = 16'(t0); stop_pos_i = 16'(t0 + 40); step_size_i = 8'd10;
        pulse_start();
        cnt = 0;
        while (!meas_req_o && cnt < 20) begin @(negedge psclk_i); cnt++; end
        chk("abort_meas_req_seen", int'(meas_req_o), 1);
        chk("start_clears_err", int'(err_o), 0);
        @(posedge psclk_i); #1 meas_ack_i = 1'b1; abort_i = 1'b1;
        @(posedge psclk_i); #1 meas_ack_i = 1'b0; abort_i = 1'b0;
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_meas_req", int'(meas_req_o), 0);
        chk("abort_point_idx", int'(point_idx_o), 0);
        chk("abort_done", int'(done_o), 0);
        @(negedge psclk_i);
        chk("abort_stays_idle", int'(busy_o), 0);

        // start beats abort in IDLE; a second start while busy is ignored
        @(posedge psclk_i); #1 start_i = 1'b1; abort_i = 1'b1;
        @(posedge psclk_i); #1 start_i = 1'b0; abort_i = 1'b0;
        chk("start_priority_busy", int'(busy_o), 1);
        start_pos_i = 16'(t0 + 77);
        pulse_start();
        chk("start_ignored_target", int'(cur_target_o), t0);
        @(posedge psclk_i); #1 abort_i = 1'b1;
        @(posedge psclk_i); #1 abort_i = 1'b0;
        chk("abort2_busy", int'(busy_o), 0);
        ack_en = 1'b1;

        // reset asserted while dwelling
        t0 = int'(total_steps_i);
        s  = (t0 + 7 == 0) ? t0 - 7 : t0 + 7;
        start_pos_i = 16'(s); stop_pos_i = 16'(s); step_size_i = 8'd1;
        dwell_cycles_i = 16'd50;
        pulse_start();
        repeat (20) @(posedge psclk_i);
        #1 chk("pre_reset_busy", int'(busy_o), 1);
        chk("pre_reset_target", int'(cur_target_o), s);
        #2 rstn_i = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge psclk_i); rstn_i = 1'b1;
        run_sweep(10, 18, 4, 1, 3, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dps_sweep_sequencer.md
DPS_SWEEP_SEQUENCER -- requirements
Module: dps_sweep_sequencer

Interface
REQ-001 SHALL have parameter MOVE_TIMEOUT, default 4096, the maximum psclk cycles allowed for one move chunk to be reflected on total_steps_i.
REQ-002 SHALL have port psclk_i, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit: one-cycle pulse that begins a sweep.
REQ-005 SHALL have port abort_i, input, 1 bit: cancels the sweep in progress.
REQ-006 SHALL have ports start_pos_i and stop_pos_i, input, 16-bit signed each: sweep endpoints in phase-shift steps.
REQ-007 SHALL have port step_size_i, input, 8 bits: increment between measurement points, valid range 1..255.
REQ-008 SHALL have port dwell_cycles_i, input, 16 bits: settle time in cycles after each move.
REQ-009 SHALL have port total_steps_i, input, 16-bit signed: accumulated phase position reported by the phase-shift controller.
REQ-010 SHALL have port meas_ack_i, input, 1 bit: measurement-complete acknowledge.
REQ-011 SHALL have port toggle_o, output, 1 bit: level toggle that requests one phase-shift burst.
REQ-012 SHALL have ports dir_o (output, 1 bit, 1 = increment) and steps_o (output, 8 bits): burst direction and length.
REQ-013 SHALL have port meas_req_o, output, 1 bit: measurement request.
REQ-014 SHALL have port cur_target_o, output, 16-bit signed: current target position.
REQ-015 SHALL have port point_idx_o, output, 16 bits: count of completed points.
REQ-016 SHALL have output ports busy_o (1 bit), done_o (1 bit, one-cycle pulse) and err_o (1 bit, sticky).

Function
REQ-017 SHALL implement the states IDLE, CALC, ISSUE, WAIT_MOVE, DWELL, MEAS and NEXT.
REQ-018 SHALL, in IDLE on start_i, latch all sweep inputs, set cur_target = start_pos, clear point_idx and err_o, assert busy_o, and go to CALC.
REQ-019 SHALL ignore start_i when not in IDLE.
REQ-020 SHALL, when start_i arrives with step_size_i = 0, set err_o, stay in IDLE, and leave busy_o low.
REQ-021 SHALL fix sweep direction at start: up if stop_pos >= start_pos, else down.
REQ-022 SHALL, in CALC, compute delta = cur_target - total_steps_i in 17-bit signed arithmetic.
REQ-023 SHALL go from CALC to DWELL when delta = 0, and otherwise to ISSUE.
REQ-024 SHALL, in ISSUE, drive dir_o = (delta > 0), drive steps_o = min(|delta|, 255), latch expected = total_steps_i ± steps_o, invert toggle_o, and go to WAIT_MOVE; all of this takes exactly one cycle.
REQ-025 SHALL hold dir_o and steps_o stable from ISSUE until the next ISSUE.
REQ-026 SHALL, in WAIT_MOVE, return to CALC on the cycle total_steps_i equals expected.
REQ-027 SHALL, when WAIT_MOVE lasts MOVE_TIMEOUT cycles, set err_o, drop busy_o, and go to IDLE without pulsing done_o.
REQ-028 SHALL, in DWELL, load a counter with dwell_cycles and decrement it each cycle, moving to MEAS when it reaches 0; dwell = 0 gives MEAS on the next cycle.
REQ-029 SHALL, in MEAS, hold meas_req_o high until meas_ack_i is sampled high, then deassert meas_req_o in the following cycle, increment point_idx_o, and go to NEXT.
REQ-030 SHALL ignore meas_ack_i outside MEAS.
REQ-031 SHALL, in NEXT, compute next = cur_target ± step_size in 17-bit signed arithmetic.
REQ-032 SHALL go from NEXT to CALC with cur_target = next when next does not pass stop_pos (next <= stop for up, next >= stop for down).
REQ-033 SHALL, when next passes stop_pos, pulse done_o for one cycle, drop busy_o, and go to IDLE.
REQ-034 SHALL end the sweep with point_idx_o = floor(|stop - start| / step) + 1.
REQ-035 SHALL perform exactly one point when start_pos = stop_pos.
REQ-036 SHALL, on abort_i in any non-IDLE state, go to IDLE on the next edge with meas_req_o = 0, busy_o = 0, no done_o pulse, and err_o unchanged; toggle_o keeps its level.
REQ-037 SHALL, when abort_i and start_i are both high in IDLE, give start_i priority.
REQ-038 SHALL, when abort_i and meas_ack_i coincide, give abort priority and leave point_idx_o unchanged.

Reset
REQ-039 SHALL, while rstn_i is low, asynchronously force state = IDLE and every output to 0 (toggle_o, dir_o, steps_o, meas_req_o, cur_target_o, point_idx_o, busy_o, done_o, err_o), together with all internal counters and latches.
REQ-040 SHALL leave reset on the first psclk_i edge after rstn_i rises, and SHALL abandon any sweep in progress when reset is asserted mid-sweep.

Verification
REQ-041 Bench SHALL cover an up sweep: start = 0, stop = 10, step = 4, dwell = 3, ideal controller model -> targets 0/4/8, three meas_req handshakes, done_o once, point_idx = 3.
REQ-042 Bench SHALL cover a large move: total = 0, start = 600 -> bursts of 255, 255 and 90, all with dir = 1, then DWELL; toggle_o changes level 3 times.
REQ-043 Bench SHALL cover a down sweep with a negative start: start = -5, stop = -12, step = 3 -> targets -5/-8/-11, then done_o, point_idx = 3.
REQ-044 Bench SHALL cover a timeout: the model never updates total_steps_i -> err_o = 1 after 4096 WAIT_MOVE cycles, busy_o = 0, done_o never asserted.
REQ-045 Bench SHALL cover abort during MEAS: abort_i coincides with meas_ack_i -> IDLE next cycle, meas_req_o = 0, point_idx unchanged.
REQ-046 Bench SHALL cover reset mid-sweep: rstn_i asserted in DWELL -> all outputs 0 immediately; a new start_i after release runs the sweep normally.
